// File: rtl/lift_car_ctrl.sv
// Single-car lift controller: latches car/hall calls, serves them collectively in
// the current direction, runs the door dwell, and handles emergency stop and faults.
module lift_car_ctrl #(
  parameter  int N            = 3,
  parameter  int DELAY_CYCLES = 50,
  parameter  int TRAVEL_LIMIT = 1000,
  localparam int CW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_l,
  input  logic [N-1:0]  i_u,
  input  logic [N-1:0]  i_d,
  input  logic [N-1:0]  sf,
  input  logic [N-2:0]  si,
  input  logic          door_obs,
  input  logic          estop,
  output logic          STOP,
  output logic          UP,
  output logic          D,
  output logic          v,
  output logic [CW-1:0] c,
  output logic [N-1:0]  Rc,
  output logic [N-1:0]  Ru,
  output logic [N-1:0]  Rd,
  output logic          fault
);
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int TW = (TRAVEL_LIMIT > 1) ? $clog2(TRAVEL_LIMIT) : 1;
  localparam logic [DW-1:0] DWELL_LOAD  = DW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_LIMIT - 1);
  localparam logic [N-1:0]  U_VALID     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  D_VALID     = {{(N-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_DOOR, S_ESTOP, S_FAULT} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            v_q, up_nxt;
  logic            srv_u, srv_d, srv_u_nxt, srv_d_nxt;
  logic [2*N-2:0]  sens_q;
  logic [N-1:0]    press_c, press_u, press_d, clr_c, clr_u, clr_d, any_req;
  logic            sf_one, sf_multi, sens_chg, timeout;
  logic [CW-1:0]   sf_idx;
  logic            ahead_up, ahead_dn, ahead_fwd, ahead_rev;
  logic            open_door, flip, reload;

  assign any_req   = Rc | Ru | Rd;
  assign sens_chg  = ({sf, si} != sens_q);
  assign ahead_fwd = UP ? ahead_up : ahead_dn;
  assign ahead_rev = UP ? ahead_dn : ahead_up;
  assign timeout   = (state == S_MOVE) && !sens_chg && (tcnt == TRAVEL_LAST);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    sf_one   = 1'b0;
    sf_multi = 1'b0;
    sf_idx   = '0;
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sf[k]) begin
        if (sf_one) sf_multi = 1'b1;
        sf_one = 1'b1;
        sf_idx = CW'(k);
      end
      if (any_req[k] && (k > int'(c))) ahead_up = 1'b1;
      if (any_req[k] && (k < int'(c))) ahead_dn = 1'b1;
    end
    sf_one = sf_one & ~sf_multi;
  end

  always_comb begin
    state_nxt = state;
    up_nxt    = UP;
    dcnt_nxt  = dcnt;
    tcnt_nxt  = tcnt;
    srv_u_nxt = srv_u;
    srv_d_nxt = srv_d;
    press_c   = i_l;
    press_u   = i_u & U_VALID;
    press_d   = i_d & D_VALID;
    clr_c     = '0;
    clr_u     = '0;
    clr_d     = '0;
    open_door = 1'b0;
    flip      = 1'b0;
    reload    = 1'b0;

    if (sf_multi || timeout || state == S_FAULT) begin
      state_nxt = S_FAULT;
    end else if (estop) begin
      state_nxt = S_ESTOP;
    end else begin
      case (state)
        S_IDLE: begin
          tcnt_nxt = '0;
          // An opposite-direction call here only opens the door once nothing lies ahead,
          // otherwise the door would reopen forever without serving it.
          if (v && (Rc[c] | (UP ? Ru[c] : Rd[c]) | ((UP ? Rd[c] : Ru[c]) & ~ahead_fwd)))
            open_door = 1'b1;
          else if (ahead_fwd)
            state_nxt = S_MOVE;
          else if (ahead_rev) begin
            up_nxt    = ~UP;
            state_nxt = S_MOVE;
          end
        end
        S_MOVE: begin
          tcnt_nxt = sens_chg ? '0 : tcnt + 1'b1;
          if (v && !v_q)
            open_door = Rc[c] | (UP ? (Ru[c] | (Rd[c] & ~ahead_up) | (c == CW'(N-1)))
                                    : (Rd[c] | (Ru[c] & ~ahead_dn) | (c == '0)));
        end
        S_DOOR: begin
          tcnt_nxt   = '0;
          reload     = door_obs | press_c[c] | (srv_u & press_u[c]) | (srv_d & press_d[c]);
          press_c[c] = 1'b0;
          if (srv_u) press_u[c] = 1'b0;
          if (srv_d) press_d[c] = 1'b0;
          if (reload)            dcnt_nxt  = DWELL_LOAD;
          else if (dcnt == '0)   state_nxt = S_IDLE;
          else                   dcnt_nxt  = dcnt - 1'b1;
        end
        S_ESTOP: state_nxt = S_IDLE;
        default: ;
      endcase
    end

    if (open_door) begin
      flip      = ~ahead_fwd;
      state_nxt = S_DOOR;
      dcnt_nxt  = DWELL_LOAD;
      srv_u_nxt = UP | flip;
      srv_d_nxt = ~UP | flip;
      clr_c[c]  = 1'b1;
      clr_u[c]  = srv_u_nxt;
      clr_d[c]  = srv_d_nxt;
      if (flip) up_nxt = ~UP;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state  <= S_IDLE;
      STOP   <= 1'b1;
      UP     <= 1'b1;
      D      <= 1'b0;
      v      <= 1'b0;
      c      <= '0;
      Rc     <= '0;
      Ru     <= '0;
      Rd     <= '0;
      fault  <= 1'b0;
      dcnt   <= '0;
      tcnt   <= '0;
      v_q    <= 1'b0;
      sens_q <= '0;
      srv_u  <= 1'b0;
      srv_d  <= 1'b0;
    end else begin
      state  <= state_nxt;
      UP     <= up_nxt;
      dcnt   <= dcnt_nxt;
      tcnt   <= tcnt_nxt;
      srv_u  <= srv_u_nxt;
      srv_d  <= srv_d_nxt;
      Rc     <= (Rc | press_c) & ~clr_c;
      Ru     <= (Ru | press_u) & ~clr_u;
      Rd     <= (Rd | press_d) & ~clr_d;
      v      <= sf_one;
      if (sf_one) c <= sf_idx;
      v_q    <= v;
      sens_q <= {sf, si};
      STOP   <= (state_nxt != S_MOVE);
      D      <= (state_nxt == S_DOOR);
      fault  <= (state_nxt == S_FAULT);
    end
  end
endmodule

// File: tb/tb_lift_car_ctrl.sv
// Scoreboard bench for lift_car_ctrl: a shaft model drives the sensors, a behavioural
// controller model predicts every output cycle, and a monitor compares the DUT.
module tb_lift_car_ctrl;
  localparam int N            = 3;
  localparam int DELAY_CYCLES = 4;
  localparam int TRAVEL_LIMIT = 64;
  localparam int CW           = 2;
  localparam int STEP         = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  i_l, i_u, i_d, sf;
  logic [N-2:0]  si;
  logic          door_obs, estop;
  logic          STOP, UP, D, v, fault;
  logic [CW-1:0] c;
  logic [N-1:0]  Rc, Ru, Rd;

  lift_car_ctrl #(.N(N), .DELAY_CYCLES(DELAY_CYCLES), .TRAVEL_LIMIT(TRAVEL_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .i_l(i_l), .i_u(i_u), .i_d(i_d), .sf(sf), .si(si),
    .door_obs(door_obs), .estop(estop), .STOP(STOP), .UP(UP), .D(D), .v(v), .c(c),
    .Rc(Rc), .Ru(Ru), .Rd(Rd), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic stop, up, d, v;
    logic [CW-1:0] c;
    logic [N-1:0] rc, ru, rd;
    logic fault;
  } obs_t;

  typedef enum {M_IDLE, M_MOVE, M_DOOR, M_ESTOP, M_FAULT} mode_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural controller model: requests indexed [kind][floor], kind 0=car 1=up 2=down.
  mode_t          m_mode;
  bit             m_up, m_v, m_vq;
  int             m_c, m_dwell, m_still;
  bit             m_req[3][N];
  bit             m_srv[3];
  bit             m_clr[3];
  bit [2*N-2:0]   m_sens;

  // Shaft model: position in half-floor steps, even = level with a floor.
  int             pos = 0, ptick = 0;
  bit             freeze = 0, force_sf = 0;
  logic [N-1:0]   forced_sf = '0;

  function automatic bit pending(input int k);
    return m_req[0][k] | m_req[1][k] | m_req[2][k];
  endfunction

  function automatic bit beyond(input int k, input bit go_up);
    for (int j = 0; j < N; j++)
      if (pending(j) && (go_up ? (j > k) : (j < k))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit door_worthy(input int k);
    bit same_dir = m_up ? m_req[1][k] : m_req[2][k];
    bit oppo_dir = m_up ? m_req[2][k] : m_req[1][k];
    return m_req[0][k] | same_dir | (oppo_dir & !beyond(k, m_up));
  endfunction

  task automatic open_door(input int k);
    bit turn = !beyond(k, m_up);
    m_srv[0] = 1'b1;
    m_srv[1] = m_up | turn;
    m_srv[2] = !m_up | turn;
    m_clr    = m_srv;
    if (turn) m_up = !m_up;
    m_dwell  = DELAY_CYCLES - 1;
  endtask

  task automatic model_step();
    mode_t nm;
    bit    press[3][N];
    bit    halt, stop_here, served;
    int    ones, k, idx;
    m_clr = '{0, 0, 0};
    if (!rst_n) begin
      m_mode = M_IDLE; m_up = 1'b1; m_v = 1'b0; m_vq = 1'b0; m_c = 0;
      m_dwell = 0; m_still = 0; m_sens = '0; m_srv = '{0, 0, 0};
      for (int j = 0; j < N; j++) begin m_req[0][j] = 0; m_req[1][j] = 0; m_req[2][j] = 0; end
      return;
    end
    k = m_c;
    for (int j = 0; j < N; j++) begin
      press[0][j] = i_l[j];
      press[1][j] = i_u[j] && (j != N-1);
      press[2][j] = i_d[j] && (j != 0);
    end
    ones = 0; idx = 0;
    for (int j = 0; j < N; j++) if (sf[j]) begin ones++; idx = j; end
    halt = (ones > 1) || (m_mode == M_FAULT) ||
           (m_mode == M_MOVE && {sf, si} == m_sens && m_still == TRAVEL_LIMIT - 1);
    nm = m_mode;
    if (halt) nm = M_FAULT;
    else if (estop) nm = M_ESTOP;
    else begin
      case (m_mode)
        M_IDLE: begin
          m_still = 0;
          if (m_v && door_worthy(k)) begin open_door(k); nm = M_DOOR; end
          else if (beyond(k, m_up)) nm = M_MOVE;
          else if (beyond(k, !m_up)) begin m_up = !m_up; nm = M_MOVE; end
        end
        M_MOVE: begin
          m_still = ({sf, si} != m_sens) ? 0 : m_still + 1;
          if (m_v && !m_vq) begin
            if (m_up) stop_here = m_req[0][k] | m_req[1][k] | (m_req[2][k] & !beyond(k, 1)) | (k == N-1);
            else      stop_here = m_req[0][k] | m_req[2][k] | (m_req[1][k] & !beyond(k, 0)) | (k == 0);
            if (stop_here) begin open_door(k); nm = M_DOOR; end
          end
        end
        M_DOOR: begin
          m_still = 0;
          served  = 1'b0;
          for (int t = 0; t < 3; t++)
            if (m_srv[t] && press[t][k]) begin served = 1'b1; press[t][k] = 1'b0; end
          if (door_obs || served) m_dwell = DELAY_CYCLES - 1;
          else if (m_dwell == 0) nm = M_IDLE;
          else m_dwell--;
        end
        M_ESTOP: nm = M_IDLE;
        default: ;
      endcase
    end
    for (int t = 0; t < 3; t++)
      for (int j = 0; j < N; j++)
        m_req[t][j] = (m_req[t][j] | press[t][j]) & !(m_clr[t] && j == k);
    m_vq = m_v;
    m_v  = (ones == 1);
    if (ones == 1) m_c = idx;
    m_sens = {sf, si};
    m_mode = nm;
  endtask

  function automatic obs_t expected();
    obs_t e;
    e.stop  = (m_mode != M_MOVE);
    e.up    = m_up;
    e.d     = (m_mode == M_DOOR);
    e.v     = m_v;
    e.c     = CW'(m_c);
    e.fault = (m_mode == M_FAULT);
    for (int j = 0; j < N; j++) begin
      e.rc[j] = m_req[0][j];
      e.ru[j] = m_req[1][j];
      e.rd[j] = m_req[2][j];
    end
    return e;
  endfunction

  task automatic plant_advance();
    if (m_mode == M_MOVE && !freeze) begin
      ptick++;
      if (ptick == STEP) begin
        ptick = 0;
        pos   = m_up ? pos + 1 : pos - 1;
        if (pos < 0) pos = 0;
        if (pos > 2*(N-1)) pos = 2*(N-1);
      end
    end else if (m_mode != M_MOVE) ptick = 0;
    sf = '0;
    si = '0;
    if (pos % 2 == 0) sf[pos/2] = 1'b1;
    else              si[pos/2] = 1'b1;
    if (force_sf) sf = forced_sf;
  endtask

  task automatic tick();
    plant_advance();
    model_step();
    exp_q.push_back(expected());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [N-1:0] l, input logic [N-1:0] u, input logic [N-1:0] d);
    i_l = l; i_u = u; i_d = d;
    tick();
    i_l = '0; i_u = '0; i_d = '0;
  endtask

  task automatic do_reset(input bit home);
    rst_n = 1'b0; i_l = '0; i_u = '0; i_d = '0; door_obs = 1'b0; estop = 1'b0;
    freeze = 1'b0; force_sf = 1'b0;
    if (home) begin pos = 0; ptick = 0; end
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_mode(input mode_t m, input int limit, input string name);
    int n = 0;
    while (m_mode != m && n < limit) begin tick(); n++; end
    if (m_mode != m) begin
      checks++; errors++;
      $display("FAIL %s: wait expired after %0d cycles, mode %s, required %s", name, n, m_mode.name(), m.name());
    end
  endtask

  function automatic string fmt(input obs_t o);
    return $sformatf("stop=%b up=%b d=%b v=%b c=%0d rc=%b ru=%b rd=%b fault=%b",
                     o.stop, o.up, o.d, o.v, o.c, o.rc, o.ru, o.rd, o.fault);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %s, required %s", name, $time, fmt(got), fmt(want));
    end
  endtask

  initial begin : monitor
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      got = {STOP, UP, D, v, c, Rc, Ru, Rd, fault};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard @%0t: DUT output with no expected entry queued", $time);
      end else begin
        check("outputs", got, exp_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    int est_left = 0;
    sf = '0; si = '0;
    do_reset(1);
    run(3);
    // Down call at the top floor: pass floor 1, open at 2, turn around.
    pulse('0, '0, 3'b100);
    run(45);
    // Car call for floor 1 while already heading up to the top.
    do_reset(1); run(2);
    pulse('0, '0, 3'b100);
    run(3);
    pulse(3'b010, '0, '0);
    run(60);
    // Obstruction held, then a same-kind press at the open floor re-arms the dwell.
    do_reset(1); run(2);
    pulse(3'b010, '0, '0);
    wait_mode(M_DOOR, 40, "door_open");
    door_obs = 1'b1; run(10); door_obs = 1'b0;
    run(2);
    pulse(3'b010, 3'b010, '0);
    run(20);
    // Emergency stop between floors, then resume.
    do_reset(1); run(2);
    pulse(3'b100, '0, '0);
    run(6);
    estop = 1'b1; run(5); estop = 1'b0;
    run(40);
    // Travel watchdog: shaft sensors never change while moving; estop cannot clear it.
    do_reset(1); run(2);
    freeze = 1'b1;
    pulse(3'b100, '0, '0);
    run(TRAVEL_LIMIT + 8);
    estop = 1'b1; run(3); estop = 1'b0;
    run(3);
    // Two floor sensors at once.
    do_reset(1); run(2);
    force_sf = 1'b1; forced_sf = 3'b011;
    run(3);
    force_sf = 1'b0;
    run(10);
    do_reset(1); run(3);
    // Randomized traffic with an occasional emergency stop and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < N; j++) begin
        i_l[j] = ($urandom_range(0, 19) == 0);
        i_u[j] = ($urandom_range(0, 24) == 0);
        i_d[j] = ($urandom_range(0, 24) == 0);
      end
      door_obs = ($urandom_range(0, 9) == 0);
      if (est_left == 0 && $urandom_range(0, 299) == 0) est_left = $urandom_range(1, 6);
      estop = (est_left > 0);
      if (est_left > 0) est_left--;
      if (i == 1500) do_reset(0);
      else tick();
    end
    i_l = '0; i_u = '0; i_d = '0; door_obs = 1'b0; estop = 1'b0;
    run(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lift_car_ctrl.md
LIFT_CAR_CTRL -- requirements
Module: lift_car_ctrl

Interface
REQ-001 SHALL have parameter N, default 3: number of floors, N >= 2.
REQ-002 SHALL have parameter DELAY_CYCLES, default 50: door-open dwell in clk cycles, >= 1.
REQ-003 SHALL have parameter TRAVEL_LIMIT, default 1000: max cycles in MOVE without any sf/si change.
REQ-004 SHALL have localparam CW = max(1, clog2(N)).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port i_l, input, N: car-panel floor buttons, level or pulse.
REQ-008 SHALL have port i_u, input, N: hall up buttons; bit N-1 ignored.
REQ-009 SHALL have port i_d, input, N: hall down buttons; bit 0 ignored.
REQ-010 SHALL have port sf, input, N: floor-level sensors, one-hot when level.
REQ-011 SHALL have port si, input, N-1: mid-shaft sensors; bit k lies between floors k and k+1.
REQ-012 SHALL have port door_obs, input, 1: door obstruction.
REQ-013 SHALL have port estop, input, 1: emergency stop.
REQ-014 SHALL have port STOP, output, 1: motor halted.
REQ-015 SHALL have port UP, output, 1: direction; 1 = up.
REQ-016 SHALL have port D, output, 1: door open.
REQ-017 SHALL have port v, output, 1: car level at a floor.
REQ-018 SHALL have port c, output, CW: last floor passed or at.
REQ-019 SHALL have port Rc, Ru, Rd, output, N each: latched car, up and down requests, for lamps.
REQ-020 SHALL have port fault, output, 1: sticky fault.
REQ-021 SHALL register all outputs.

Function
REQ-022 SHALL set Rc/Ru/Rd bit k the cycle after the matching button is high; bits stay set until served; ignored bits stay 0.
REQ-023 SHALL register v = (sf has exactly one bit set) and SHALL load c with the index of that bit whenever v would be 1.
REQ-024 SHALL define ahead_up = any (Rc|Ru|Rd) bit above c, and ahead_dn = any bit below c.
REQ-025 SHALL implement states IDLE, MOVE, DOOR, ESTOP, FAULT.
REQ-026 IDLE: STOP=1, D=0; with v=1 and any request at c -> DOOR. Else, if a request lies ahead in the current UP direction -> MOVE, UP unchanged. Else, if a request lies in the other direction -> flip UP, then MOVE. Else remain.
REQ-027 MOVE: STOP=0, D=0; evaluate a stop only on a 0->1 edge of v (arrival), at floor k = c.
REQ-028 Moving up, SHALL stop at k if Rc[k] | Ru[k] | (Rd[k] & no requests above k) | k == N-1. Moving down is symmetric with Rd/Ru and floor 0. Stop -> DOOR next cycle.
REQ-029 On DOOR entry: clear Rc[k] and the hall call matching UP. If no requests lie ahead of k, flip UP and also clear the opposite hall call at k.
REQ-030 DOOR: STOP=1, D=1; dwell counter loads DELAY_CYCLES-1 and decrements each cycle.
REQ-031 In DOOR, SHALL reload the counter while door_obs=1, or when a button for floor k matching the served kind is pressed; that press is not latched.
REQ-032 SHALL leave DOOR -> IDLE when the counter is 0 and door_obs=0; D falls in the same cycle as the IDLE entry.
REQ-033 estop=1 SHALL force ESTOP from IDLE/MOVE/DOOR next cycle: STOP=1, D=0, requests retained, counters frozen. estop=0 -> IDLE.
REQ-034 SHALL enter FAULT when sf has more than one bit set, or when MOVE sees no sf/si change for TRAVEL_LIMIT cycles.
REQ-035 FAULT: STOP=1, D=0, fault=1; SHALL clear only by reset. FAULT takes precedence over estop.
REQ-036 Simultaneous press and service of the same bit in one cycle SHALL leave the bit clear.

Reset
REQ-037 SHALL drive, in the cycle after rst_n=0 is sampled: state IDLE, STOP=1, UP=1, D=0, v=0, c=0, Rc=Ru=Rd=0, fault=0, counters 0.
REQ-038 Reset mid-MOVE or mid-DOOR SHALL discard all requests.
REQ-039 rst_n SHALL take priority over all other inputs.

Verification (N=3, DELAY_CYCLES=4, TRAVEL_LIMIT=64)
REQ-040 At floor 0, press i_d[2] -> Rd=100; MOVE with UP=1; passes floor 1 without stopping; DOOR at c=2 for 4 cycles; UP=0; Rd=000.
REQ-041 Car moving up from 0 with Rd[2] latched, press i_l[1] -> stops at c=1; Rc cleared; D=1; then continues to 2.
REQ-042 In DOOR, hold door_obs for 10 cycles -> D stays 1 for 10+4 cycles.
REQ-043 Assert estop mid-MOVE -> next cycle STOP=1, D=0; requests kept; release -> resumes to target.
REQ-044 Drive sf=011 -> fault=1, STOP=1, and these persist until rst_n=0.
REQ-045 Hold sf/si constant in MOVE for 64 cycles -> fault=1.
